// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC access arbiter.
//   crtc_state_t : arbiter sequencing states
//   crtc_wr_t    : one queued ASIC register write {addr, data}
//   FIFO_DEPTH / REG_W / DATA_W / PTR_W / LEVEL_W : sizing constants
package crtc_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int REG_W      = 5;
  localparam int DATA_W     = 8;
  localparam int PTR_W      = 2;  // log2(FIFO_DEPTH)
  localparam int LEVEL_W    = 3;  // holds 0..FIFO_DEPTH without wrapping

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEL     = 2'd1,
    ST_DATA    = 2'd2,
    ST_RESTORE = 2'd3
  } crtc_state_t;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } crtc_wr_t;

endpackage

// File: rtl/crtc_wr_fifo.sv
// Four-entry write-request FIFO for the CRTC access arbiter.
//   CLOCK, nRESET : clock, asynchronous active-low reset (clears to empty)
//   push, wdata   : enqueue wdata on the edge when push=1 and not full
//   pop, rdata    : rdata is the head entry; pop removes it (ignored when empty)
//   full, empty   : occupancy flags
//   level         : entry count 0..FIFO_DEPTH
// No bypass: a pushed entry becomes visible at rdata one cycle later.
module crtc_wr_fifo
  import crtc_pkg::*;
(
  input  logic               CLOCK,
  input  logic               nRESET,
  input  logic               push,
  input  crtc_wr_t           wdata,
  input  logic               pop,
  output crtc_wr_t           rdata,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  crtc_wr_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge CLOCK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the level unchanged.
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/crtc_access_arbiter.sv
// Shares the CRTC register port between the CPU and queued ASIC writes.
//   CLOCK, nRESET      : clock, asynchronous active-low reset
//   CLKEN              : character clock enable; one ASIC bus slot per pulse
//   arb_en             : ASIC access enabled
//   cpu_en/ncs/rnw/rs/di : CPU bus, passed straight through when active
//   asic_wr_valid/ready/reg/data : ASIC write request (valid/ready)
//   crtc_enable/ncs/rnw/rs/do : CRTC bus
//   busy, fifo_level, commit : status (commit pulses in the data-write slot)
//   fsm_state          : current sequencing state, for observation
//
// Handshake: a request transfers on a CLOCK edge where asic_wr_valid and
// asic_wr_ready are both 1. The requester must hold valid and its payload
// stable until that edge; ready never depends on valid.
//
// Each ASIC entry is written as: select reg (rs=0), write data (rs=1), then
// the CPU's last select is restored (rs=0) so the CPU never notices. Back-to-
// back entries skip the restore until the queue drains.
module crtc_access_arbiter
  import crtc_pkg::*;
(
  input  logic               CLOCK,
  input  logic               nRESET,
  input  logic               CLKEN,
  input  logic               arb_en,
  input  logic               cpu_en,
  input  logic               cpu_ncs,
  input  logic               cpu_rnw,
  input  logic               cpu_rs,
  input  logic [DATA_W-1:0]  cpu_di,
  input  logic               asic_wr_valid,
  output logic               asic_wr_ready,
  input  logic [REG_W-1:0]   asic_wr_reg,
  input  logic [DATA_W-1:0]  asic_wr_data,
  output logic               crtc_enable,
  output logic               crtc_ncs,
  output logic               crtc_rnw,
  output logic               crtc_rs,
  output logic [DATA_W-1:0]  crtc_do,
  output logic               busy,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               commit,
  output crtc_state_t        fsm_state
);

  crtc_state_t       state;
  logic [REG_W-1:0]  shadow;
  logic [REG_W-1:0]  hold_reg;
  logic [DATA_W-1:0] hold_data;

  logic     cpu_act;
  logic     cpu_sel_wr;
  logic     step;
  logic     data_done;
  logic     push;
  logic     pop;
  logic     fifo_full;
  logic     fifo_empty;
  crtc_wr_t fifo_head;
  crtc_wr_t fifo_in;

  assign cpu_act    = cpu_en & ~cpu_ncs;
  assign cpu_sel_wr = cpu_act & ~cpu_rnw & ~cpu_rs;
  // The CPU owns every slot it is active in; ASIC only uses idle CLKEN slots.
  assign step       = CLKEN & ~cpu_act & (state != ST_IDLE);
  assign data_done  = step & (state == ST_DATA);

  assign asic_wr_ready = arb_en & ~fifo_full;
  assign push          = asic_wr_valid & asic_wr_ready;
  assign fifo_in       = '{addr: asic_wr_reg, data: asic_wr_data};
  // Load the next entry from IDLE, or chain directly after a data write.
  assign pop           = arb_en & ~fifo_empty & ((state == ST_IDLE) | data_done);

  assign busy      = (state != ST_IDLE) | ~fifo_empty;
  assign commit    = data_done;
  assign fsm_state = state;

  crtc_wr_fifo u_fifo (
    .CLOCK  (CLOCK),
    .nRESET (nRESET),
    .push   (push),
    .wdata  (fifo_in),
    .pop    (pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      hold_reg  <= '0;
      hold_data <= '0;
    end else begin
      if (cpu_sel_wr) shadow <= cpu_di[REG_W-1:0];
      if (pop) begin
        hold_reg  <= fifo_head.addr;
        hold_data <= fifo_head.data;
      end
      case (state)
        ST_IDLE:    if (pop) state <= ST_SEL;
        ST_SEL:     if (step) state <= ST_DATA;
        ST_DATA: begin
          // A CPU select in between would redirect our data write, so the
          // select is issued again with the held entry.
          if (cpu_sel_wr)  state <= ST_SEL;
          else if (step)   state <= pop ? ST_SEL : ST_RESTORE;
        end
        ST_RESTORE: if (step) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    crtc_enable = 1'b0;
    crtc_ncs    = 1'b1;
    crtc_rnw    = 1'b1;
    crtc_rs     = 1'b0;
    crtc_do     = '0;
    if (cpu_act) begin
      crtc_enable = cpu_en;
      crtc_ncs    = cpu_ncs;
      crtc_rnw    = cpu_rnw;
      crtc_rs     = cpu_rs;
      crtc_do     = cpu_di;
    end else if (step) begin
      crtc_enable = 1'b1;
      crtc_ncs    = 1'b0;
      crtc_rnw    = 1'b0;
      case (state)
        ST_SEL: begin
          crtc_rs = 1'b0;
          crtc_do = {{(DATA_W-REG_W){1'b0}}, hold_reg};
        end
        ST_DATA: begin
          crtc_rs = 1'b1;
          crtc_do = hold_data;
        end
        ST_RESTORE: begin
          crtc_rs = 1'b0;
          crtc_do = {{(DATA_W-REG_W){1'b0}}, shadow};
        end
        default: begin
          crtc_rs = 1'b0;
          crtc_do = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crtc_access_arbiter.sv
// Bench for crtc_access_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the write protocol.
module tb_crtc_access_arbiter;
  import crtc_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLOCK = 1'b0;
  logic nRESET;
  always #5 CLOCK = ~CLOCK;

  logic        CLKEN, arb_en;
  logic        cpu_en, cpu_ncs, cpu_rnw, cpu_rs;
  logic [7:0]  cpu_di;
  logic        asic_wr_valid, asic_wr_ready;
  logic [4:0]  asic_wr_reg;
  logic [7:0]  asic_wr_data;
  logic        crtc_enable, crtc_ncs, crtc_rnw, crtc_rs;
  logic [7:0]  crtc_do;
  logic        busy, commit;
  logic [2:0]  fifo_level;
  crtc_state_t fsm_state;

  crtc_access_arbiter dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .arb_en(arb_en),
    .cpu_en(cpu_en), .cpu_ncs(cpu_ncs), .cpu_rnw(cpu_rnw), .cpu_rs(cpu_rs),
    .cpu_di(cpu_di), .asic_wr_valid(asic_wr_valid),
    .asic_wr_ready(asic_wr_ready), .asic_wr_reg(asic_wr_reg),
    .asic_wr_data(asic_wr_data), .crtc_enable(crtc_enable),
    .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw), .crtc_rs(crtc_rs),
    .crtc_do(crtc_do), .busy(busy), .fifo_level(fifo_level),
    .commit(commit), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // ASIC bus writes seen on the CRTC side, as {rs, do}
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  int         n_commit;

  // Reference model: pending queue, current entry and which of its three
  // bus writes (0 select, 1 data, 2 restore) comes next.
  logic [12:0] m_fifo[$];
  bit          m_active;
  int          m_phase;
  logic [4:0]  m_hreg, m_shadow;
  logic [7:0]  m_hdata;
  bit          last_acc;

  task automatic model_reset();
    m_fifo.delete();
    m_active = 0;
    m_phase  = 0;
    m_hreg   = '0;
    m_hdata  = '0;
    m_shadow = '0;
  endtask

  // Inputs are driven by callers at posedge+1; outputs checked at negedge+2.
  task automatic run_cycle();
    bit          act, sel_wr, stp, exp_rdy, psh;
    logic [11:0] exp_bus;
    logic [12:0] head;
    @(negedge CLOCK);
    #2;
    act     = cpu_en && !cpu_ncs;
    sel_wr  = act && !cpu_rnw && !cpu_rs;
    stp     = CLKEN && !act && m_active;
    exp_rdy = arb_en && (m_fifo.size() < 4);
    if (act)
      exp_bus = {1'b1, cpu_ncs, cpu_rnw, cpu_rs, cpu_di};
    else if (stp && m_phase == 0)
      exp_bus = {4'b1000, 3'b000, m_hreg};
    else if (stp && m_phase == 1)
      exp_bus = {4'b1001, m_hdata};
    else if (stp)
      exp_bus = {4'b1000, 3'b000, m_shadow};
    else
      exp_bus = {4'b0110, 8'h00};
    check("crtc_bus", {4'h0, crtc_enable, crtc_ncs, crtc_rnw, crtc_rs, crtc_do},
          {4'h0, exp_bus});
    check("commit", {15'd0, commit}, {15'd0, stp && m_phase == 1});
    check("ready", {15'd0, asic_wr_ready}, {15'd0, exp_rdy});
    check("level", {13'd0, fifo_level}, 16'(m_fifo.size()));
    check("busy", {15'd0, busy}, {15'd0, m_active || m_fifo.size() > 0});
    if (!act && crtc_enable) obs_q.push_back({crtc_rs, crtc_do});
    n_commit += int'(commit);
    // model advance for the coming edge
    psh = asic_wr_valid && exp_rdy;
    if (!m_active) begin
      if (m_fifo.size() > 0 && arb_en) begin
        head = m_fifo.pop_front();
        {m_hreg, m_hdata} = head;
        m_active = 1;
        m_phase  = 0;
      end
    end else if (m_phase == 1 && sel_wr) begin
      m_phase = 0;
    end else if (stp) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (m_fifo.size() > 0 && arb_en) begin
          head = m_fifo.pop_front();
          {m_hreg, m_hdata} = head;
          m_phase = 0;
        end else m_phase = 2;
      end else m_active = 0;
    end
    if (sel_wr) m_shadow = cpu_di[4:0];
    if (psh) m_fifo.push_back({asic_wr_reg, asic_wr_data});
    last_acc = psh;
    @(posedge CLOCK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    CLKEN = 0; cpu_en = 0; cpu_ncs = 1; cpu_rnw = 1; cpu_rs = 0; cpu_di = 0;
    asic_wr_valid = 0; asic_wr_reg = 0; asic_wr_data = 0;
  endtask

  task automatic apply_reset();
    bus_idle();
    nRESET = 0;
    model_reset();
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    nRESET = 1;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, 16'(obs_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, {7'd0, obs_q[i]}, {7'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx, guard;
    arb_en = 1;
    bus_idle();
    nRESET = 0;
    model_reset();
    #12;
    // reset state
    check("rst_bus", {12'd0, crtc_enable, crtc_ncs, crtc_rnw, crtc_rs}, 16'h0006);
    check("rst_level", {13'd0, fifo_level}, 16'd0);
    check("rst_ready", {15'd0, asic_wr_ready}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    apply_reset();

    // Single write with shadow 12 and CLKEN every 4th cycle
    cpu_en = 1; cpu_ncs = 0; cpu_rnw = 0; cpu_rs = 0; cpu_di = 8'd12;
    run_cycle();
    bus_idle();
    asic_wr_valid = 1; asic_wr_reg = 5'd1; asic_wr_data = 8'h28;
    run_cycle();
    asic_wr_valid = 0;
    obs_q.delete(); n_commit = 0;
    for (int c = 0; c < 30; c++) begin
      CLKEN = (c % 4 == 3);
      run_cycle();
    end
    exp_q = '{9'h001, 9'h128, 9'h00C};
    compare_log("single");
    check("single_commits", 16'(n_commit), 16'd1);
    check("single_busy", {15'd0, busy}, 16'd0);

    // Three back-to-back entries, one restore at the end
    apply_reset();
    obs_q.delete();
    CLKEN = 1;
    for (int i = 0; i < 3; i++) begin
      asic_wr_valid = 1; asic_wr_reg = 5'(i + 4); asic_wr_data = 8'(8'h50 + i);
      exp_q.push_back({1'b0, 3'b000, 5'(i + 4)});
      exp_q.push_back({1'b1, 8'(8'h50 + i)});
      run_cycle();
    end
    asic_wr_valid = 0;
    exp_q.push_back(9'h000);
    for (int c = 0; c < 15; c++) run_cycle();
    compare_log("b2b");

    // Full FIFO with no CLKEN, then drain
    apply_reset();
    n_commit = 0; idx = 0;
    for (int c = 0; c < 10; c++) begin
      asic_wr_valid = (idx < 6);
      asic_wr_reg   = 5'(idx + 3);
      asic_wr_data  = 8'(8'hA0 + idx);
      run_cycle();
      if (last_acc) idx++;
    end
    check("full_accepted", 16'(idx), 16'd5);
    check("full_level", {13'd0, fifo_level}, 16'd4);
    check("full_ready", {15'd0, asic_wr_ready}, 16'd0);
    CLKEN = 1; guard = 0;
    while ((idx < 6 || busy) && guard < 100) begin
      asic_wr_valid = (idx < 6);
      asic_wr_reg   = 5'(idx + 3);
      asic_wr_data  = 8'(8'hA0 + idx);
      run_cycle();
      if (last_acc) idx++;
      guard++;
    end
    asic_wr_valid = 0;
    check("drain_timeout", 16'(guard < 100), 16'd1);
    check("drain_commits", 16'(n_commit), 16'd6);
    obs_q.delete();

    // Reset asserted while the select is pending
    apply_reset();
    asic_wr_valid = 1; asic_wr_reg = 5'd9; asic_wr_data = 8'h77;
    run_cycle();
    asic_wr_valid = 0;
    guard = 0;
    while (!(m_active && m_phase == 0) && guard < 10) begin
      run_cycle();
      guard++;
    end
    check("sel_reached", 16'(m_active && m_phase == 0), 16'd1);
    CLKEN = 1;
    #2 nRESET = 0;
    #1;
    check("mid_rst_bus", {4'h0, crtc_enable, crtc_ncs, crtc_rnw, crtc_rs, crtc_do},
          16'h0600);
    check("mid_rst_level", {13'd0, fifo_level}, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, asic_wr_ready}, {15'd0, arb_en});
    model_reset();
    @(negedge CLOCK);
    nRESET = 1;
    @(posedge CLOCK);
    #1;
    obs_q.delete();
    for (int c = 0; c < 8; c++) run_cycle();
    compare_log("no_restore");

    // Randomized traffic
    apply_reset();
    last_acc = 0;
    for (int c = 0; c < 2500; c++) begin
      if (!asic_wr_valid || last_acc) begin
        asic_wr_valid = ($urandom_range(0, 2) == 0);
        asic_wr_reg   = 5'($urandom);
        asic_wr_data  = 8'($urandom);
      end
      CLKEN   = ($urandom_range(0, 2) == 0);
      cpu_en  = ($urandom_range(0, 4) == 0);
      cpu_ncs = ($urandom_range(0, 5) == 0);
      cpu_rnw = 1'($urandom);
      cpu_rs  = 1'($urandom);
      cpu_di  = 8'($urandom);
      if ($urandom_range(0, 39) == 0) arb_en = ~arb_en;
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
